// File: rtl/jtag_uart_ctrl_if.sv
// Bundle between jtag_uart_ctrl and its neighbours: two TX byte requesters,
// the RX byte stream and the Avalon-MM port toward the jtag_uart slave.
interface jtag_uart_ctrl_if;
    logic        tx0_valid;
    logic [7:0]  tx0_data;
    logic        tx0_ready;
    logic        tx1_valid;
    logic [7:0]  tx1_data;
    logic        tx1_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        av_chipselect;
    logic        av_address;
    logic        av_read_n;
    logic        av_write_n;
    logic [31:0] av_writedata;
    logic [31:0] av_readdata;
    logic        av_waitrequest;

    modport master (
        input  tx0_valid, tx0_data, tx1_valid, tx1_data, rx_ready,
               av_readdata, av_waitrequest,
        output tx0_ready, tx1_ready, rx_valid, rx_data,
               av_chipselect, av_address, av_read_n, av_write_n, av_writedata
    );

    modport slave (
        output tx0_valid, tx0_data, tx1_valid, tx1_data, rx_ready,
               av_readdata, av_waitrequest,
        input  tx0_ready, tx1_ready, rx_valid, rx_data,
               av_chipselect, av_address, av_read_n, av_write_n, av_writedata
    );
endinterface

// File: rtl/jtag_uart_ctrl.sv
// Avalon-MM sequencer for the JTAG UART: arbitrates two TX requesters, tracks TX credit
// via control-register reads and drains the RX FIFO into a one-entry holding register.
module jtag_uart_ctrl #(
    parameter int unsigned POLL_INTERVAL = 256
) (
    input  logic             clk,
    input  logic             reset,
    jtag_uart_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CTRL = 2'd1,
        RD_DATA = 2'd2,
        WR_DATA = 2'd3
    } state_t;

    localparam logic [15:0] POLL_LAST = 16'(POLL_INTERVAL - 1);

    state_t      state;
    logic [15:0] credit;
    logic [15:0] poll_cnt;
    logic        rx_due;
    logic        rr_ptr;

    logic        rx_vld_q;
    logic [7:0]  rx_dat_q;
    logic        cs_q;
    logic        addr_q;
    logic        rd_n_q;
    logic        wr_n_q;
    logic [31:0] wdata_q;

    logic        in_idle;
    logic        any_tx;
    logic        rd_go;
    logic        ctrl_go;
    logic        wr_go;
    logic        grant1;
    logic        poll_hit;
    logic        xfer_done;
    logic [15:0] rd_avail;
    logic        rd_rvalid;
    logic [7:0]  wr_byte;

    assign in_idle   = (state == IDLE);
    assign any_tx    = bus.tx0_valid | bus.tx1_valid;
    assign rd_go     = in_idle & rx_due & ~rx_vld_q;
    assign ctrl_go   = in_idle & ~rd_go & any_tx & (credit == 16'd0);
    assign wr_go     = in_idle & ~rd_go & any_tx & (credit != 16'd0);
    // A lone valid requester wins regardless of where the pointer sits.
    assign grant1    = (bus.tx0_valid & bus.tx1_valid) ? rr_ptr : bus.tx1_valid;
    assign poll_hit  = in_idle & ~rx_vld_q & (poll_cnt == POLL_LAST);
    assign xfer_done = ~in_idle & ~bus.av_waitrequest;
    assign rd_avail  = bus.av_readdata[31:16];
    assign rd_rvalid = bus.av_readdata[15];
    assign wr_byte   = grant1 ? bus.tx1_data : bus.tx0_data;

    // Ready is the IDLE-cycle grant itself, so the byte is taken on the same
    // edge that launches the write one cycle later.
    assign bus.tx0_ready = wr_go & ~grant1;
    assign bus.tx1_ready = wr_go &  grant1;

    assign bus.rx_valid      = rx_vld_q;
    assign bus.rx_data       = rx_dat_q;
    assign bus.av_chipselect = cs_q;
    assign bus.av_address    = addr_q;
    assign bus.av_read_n     = rd_n_q;
    assign bus.av_write_n    = wr_n_q;
    assign bus.av_writedata  = wdata_q;

    logic unused_rd_bits;
    assign unused_rd_bits = ^bus.av_readdata[14:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            credit   <= 16'd0;
            poll_cnt <= 16'd0;
            rx_due   <= 1'b1;
            rr_ptr   <= 1'b0;
            rx_vld_q <= 1'b0;
            rx_dat_q <= 8'h00;
            cs_q     <= 1'b0;
            addr_q   <= 1'b0;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            wdata_q  <= 32'h0;
        end else begin
            if (rx_vld_q && bus.rx_ready) begin
                rx_vld_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_vld_q) begin
                        poll_cnt <= poll_hit ? 16'd0 : poll_cnt + 16'd1;
                    end
                    if (rd_go) begin
                        state  <= RD_DATA;
                        cs_q   <= 1'b1;
                        addr_q <= 1'b0;
                        rd_n_q <= 1'b0;
                        rx_due <= 1'b0;
                    end else begin
                        if (poll_hit) begin
                            rx_due <= 1'b1;
                        end
                        if (ctrl_go) begin
                            state  <= RD_CTRL;
                            cs_q   <= 1'b1;
                            addr_q <= 1'b1;
                            rd_n_q <= 1'b0;
                        end else if (wr_go) begin
                            state   <= WR_DATA;
                            cs_q    <= 1'b1;
                            addr_q  <= 1'b0;
                            wr_n_q  <= 1'b0;
                            wdata_q <= {24'h0, wr_byte};
                            rr_ptr  <= ~grant1;
                        end
                    end
                end

                RD_CTRL: begin
                    if (xfer_done) begin
                        state  <= IDLE;
                        cs_q   <= 1'b0;
                        rd_n_q <= 1'b1;
                        credit <= rd_avail;
                    end
                end

                RD_DATA: begin
                    if (xfer_done) begin
                        state  <= IDLE;
                        cs_q   <= 1'b0;
                        rd_n_q <= 1'b1;
                        if (rd_rvalid) begin
                            rx_vld_q <= 1'b1;
                            rx_dat_q <= bus.av_readdata[7:0];
                        end
                        // More bytes queued behind this one: fetch without waiting for the timer.
                        if (rd_avail > 16'd1) begin
                            rx_due <= 1'b1;
                        end
                    end
                end

                WR_DATA: begin
                    if (xfer_done) begin
                        state  <= IDLE;
                        cs_q   <= 1'b0;
                        wr_n_q <= 1'b1;
                        if (credit != 16'd0) begin
                            credit <= credit - 16'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_uart_ctrl.sv
// Bench for jtag_uart_ctrl: UART slave model, directed scenarios with literal
// expectations, and a randomized run checked every cycle against a reference model.
module tb_jtag_uart_ctrl;
    localparam int P = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    jtag_uart_ctrl_if bus();
    jtag_uart_ctrl #(.POLL_INTERVAL(P)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int          kind;   // 1 control read, 2 data read, 3 data write
        logic [31:0] dat;
        int          at;
    } xfer_t;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // UART slave side
    int          wspace = 0;
    bit          drain_en = 0;
    bit          rand_wait = 0;
    int          force_wait = 0;
    byte unsigned urx[$];
    // stimulus side
    byte unsigned q0[$];
    byte unsigned q1[$];
    int          rx_mode = 1;  // 0 hold off, 1 always take, 2 random
    bit          gen_en = 0;
    // observation
    xfer_t       xlog[$];
    int          grants[$];
    int          wr_len = 0;
    int          last_wr_len = 0;

    // reference model
    int          m_kind;
    logic        m_addr;
    logic [31:0] m_wdata;
    logic [15:0] m_credit;
    bit          m_due;
    int          m_timer;
    bit          m_hv;
    logic [7:0]  m_hd;
    bit          m_ptr;

    task automatic model_reset();
        m_kind = 0; m_addr = 1'b0; m_wdata = 32'h0; m_credit = 16'h0;
        m_due = 1'b1; m_timer = 0; m_hv = 1'b0; m_hd = 8'h00; m_ptr = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0h, want %0h", name, cyc, got, want);
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({bus.av_chipselect, bus.av_address, bus.av_read_n, bus.av_write_n,
                    bus.av_writedata, bus.rx_valid, bus.rx_data, bus.tx0_ready, bus.tx1_ready});
    endfunction

    function automatic int count_kind(input int k);
        int n = 0;
        foreach (xlog[i]) if (xlog[i].kind == k) n++;
        return n;
    endfunction

    // Input driver and UART slave responder, #1 after each rising edge.
    initial begin
        logic [7:0] head;
        bus.tx0_valid = 0; bus.tx0_data = 0; bus.tx1_valid = 0; bus.tx1_data = 0;
        bus.rx_ready = 0; bus.av_readdata = 0; bus.av_waitrequest = 0;
        forever begin
            @(posedge clk);
            #1;
            if (gen_en) begin
                if ($urandom_range(0, 15) == 0 && urx.size() < 6) urx.push_back(8'($urandom));
                if ($urandom_range(0, 3) == 0 && q0.size() < 4) q0.push_back(8'($urandom));
                if ($urandom_range(0, 4) == 0 && q1.size() < 4) q1.push_back(8'($urandom));
            end
            if (drain_en && wspace < 64 && $urandom_range(0, 2) == 0) wspace++;
            bus.tx0_valid = (q0.size() > 0);
            bus.tx0_data  = (q0.size() > 0) ? q0[0] : 8'($urandom);
            bus.tx1_valid = (q1.size() > 0);
            bus.tx1_data  = (q1.size() > 0) ? q1[0] : 8'($urandom);
            bus.rx_ready  = (rx_mode == 1) || (rx_mode == 2 && $urandom_range(0, 1) == 1);
            if (bus.av_chipselect) begin
                if (!bus.av_write_n && force_wait > 0) begin
                    bus.av_waitrequest = 1'b1;
                    force_wait--;
                end else begin
                    bus.av_waitrequest = rand_wait && ($urandom_range(0, 2) == 0);
                end
            end else begin
                bus.av_waitrequest = 1'($urandom_range(0, 1));
            end
            if (bus.av_chipselect && !bus.av_read_n) begin
                head = (urx.size() > 0) ? urx[0] : 8'h00;
                bus.av_readdata = bus.av_address ? {16'(wspace), 16'h0}
                                : {16'(urx.size()), (urx.size() > 0), 7'h0, head};
            end else begin
                bus.av_readdata = $urandom;
            end
        end
    end

    // Compare process: checks DUT outputs against the model, then advances the model.
    initial begin : compare
        bit v0, v1, idle, rdgo, wrgo, g1, hv_old, hit, done;
        logic [63:0] expv;
        model_reset();
        forever begin
            @(negedge clk);
            if (reset) begin
                model_reset();
                wr_len = 0;
            end else begin
                cyc++;
                v0 = bus.tx0_valid;
                v1 = bus.tx1_valid;
                idle = (m_kind == 0);
                rdgo = idle && m_due && !m_hv;
                wrgo = idle && !rdgo && (v0 || v1) && (m_credit != 0);
                g1 = (v0 && v1) ? m_ptr : v1;
                expv = 64'({(m_kind != 0), m_addr, !(m_kind == 1 || m_kind == 2), !(m_kind == 3),
                            m_wdata, m_hv, m_hd, wrgo && !g1, wrgo && g1});
                check("outputs", dut_vec(), expv);
                if (!bus.av_write_n) wr_len++;

                hv_old = m_hv;
                if (m_hv && bus.rx_ready) m_hv = 1'b0;
                done = (m_kind != 0) && !bus.av_waitrequest;
                if (idle) begin
                    hit = 1'b0;
                    if (!hv_old) begin
                        if (m_timer == P - 1) begin m_timer = 0; hit = 1'b1; end
                        else m_timer++;
                    end
                    if (rdgo) begin
                        m_kind = 2; m_addr = 1'b0; m_due = 1'b0;
                    end else begin
                        if (hit) m_due = 1'b1;
                        if ((v0 || v1) && m_credit == 0) begin
                            m_kind = 1; m_addr = 1'b1;
                        end else if (v0 || v1) begin
                            m_kind = 3; m_addr = 1'b0;
                            m_wdata = {24'h0, g1 ? bus.tx1_data : bus.tx0_data};
                            m_ptr = !g1;
                            grants.push_back(int'(g1));
                            if (g1) q1.delete(0); else q0.delete(0);
                        end
                    end
                end else if (done) begin
                    case (m_kind)
                        1: begin
                            m_credit = bus.av_readdata[31:16];
                            xlog.push_back('{1, bus.av_readdata, cyc});
                        end
                        2: begin
                            if (bus.av_readdata[15]) begin
                                m_hv = 1'b1;
                                m_hd = bus.av_readdata[7:0];
                            end
                            if (bus.av_readdata[31:16] > 1) m_due = 1'b1;
                            if (urx.size() > 0) urx.delete(0);
                            xlog.push_back('{2, bus.av_readdata, cyc});
                        end
                        default: begin
                            check("tx_fifo_space", 64'(wspace > 0), 64'd1);
                            if (wspace > 0) wspace--;
                            if (m_credit != 0) m_credit = m_credit - 16'd1;
                            last_wr_len = wr_len;
                            xlog.push_back('{3, bus.av_writedata, cyc});
                        end
                    endcase
                    wr_len = 0;
                    m_kind = 0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        q0.delete(); q1.delete(); urx.delete(); xlog.delete(); grants.delete();
        gen_en = 0; rand_wait = 0; drain_en = 0; force_wait = 0; rx_mode = 1;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
    endtask

    task automatic wait_log(input int n, input string name);
        for (int i = 0; i < 300 && xlog.size() < n; i++) @(posedge clk);
        check(name, 64'(xlog.size() >= n), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        #1 check("reset_outputs", dut_vec(),
                 64'({1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0}));

        // Credit fetch
        do_reset();
        wspace = 64;
        q0.push_back(8'h41);
        wait_log(3, "cf_count");
        check("cf_first_rd_data", 64'(xlog[0].kind), 64'd2);
        check("cf_rd_data_val", 64'(xlog[0].dat), 64'h0);
        check("cf_rd_ctrl", 64'(xlog[1].kind), 64'd1);
        check("cf_ctrl_val", 64'(xlog[1].dat), 64'h0040_0000);
        check("cf_write", 64'(xlog[2].kind), 64'd3);
        check("cf_write_data", 64'(xlog[2].dat), 64'h0000_0041);
        check("cf_grant", 64'(grants[0]), 64'd0);
        check("cf_credit", 64'(m_credit), 64'h3F);

        // Round-robin with credit 4
        do_reset();
        wspace = 4;
        q0 = '{8'hA0, 8'hA1, 8'hA2};
        q1 = '{8'hB0, 8'hB1, 8'hB2};
        wait_log(7, "rr_count");
        check("rr_kinds", 64'({4'(xlog[0].kind), 4'(xlog[1].kind), 4'(xlog[2].kind), 4'(xlog[3].kind),
                               4'(xlog[4].kind), 4'(xlog[5].kind), 4'(xlog[6].kind)}), 64'h2133331);
        check("rr_grants", 64'({grants[0][0], grants[1][0], grants[2][0], grants[3][0]}), 64'b0101);
        check("rr_data", 64'({xlog[2].dat[7:0], xlog[3].dat[7:0], xlog[4].dat[7:0], xlog[5].dat[7:0]}),
              64'hA0B0A1B1);

        // Wait states on a write
        do_reset();
        wspace = 64;
        force_wait = 3;
        q0.push_back(8'h5A);
        wait_log(3, "ws_count");
        check("ws_strobe_len", 64'(last_wr_len), 64'd4);
        check("ws_data", 64'(xlog[2].dat), 64'h5A);
        check("ws_credit", 64'(m_credit), 64'd63);

        // RX burst
        do_reset();
        urx = '{8'h55, 8'h56};
        rx_mode = 0;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge clk);
            if (bus.rx_valid) found = 1;
        end
        check("rxb_first_shown", 64'(found), 64'd1);
        check("rxb_first_byte", 64'(bus.rx_data), 64'h55);
        check("rxb_first_read", 64'(xlog[0].dat), 64'h0002_8055);
        rx_mode = 1;
        wait_log(2, "rxb_count");
        check("rxb_second_read", 64'(xlog[1].dat), 64'h0001_8056);
        check("rxb_no_timer_wait", 64'((xlog[1].at - xlog[0].at) <= 4), 64'd1);
        @(negedge clk);
        check("rxb_second_byte", 64'({bus.rx_valid, bus.rx_data}), 64'h156);

        // RX backpressure: holding register stays full
        do_reset();
        urx = '{8'h01, 8'h02, 8'h03};
        rx_mode = 0;
        wspace = 64;
        drain_en = 1;
        for (int i = 0; i < 20; i++) begin
            q0.push_back(8'(i));
            q1.push_back(8'(i + 100));
        end
        repeat (1000) @(posedge clk);
        check("bp_data_reads", 64'(count_kind(2)), 64'd1);
        check("bp_writes", 64'(count_kind(3)), 64'd40);
        check("bp_held", 64'({bus.rx_valid, bus.rx_data}), 64'h101);

        // Reset during a stalled write
        do_reset();
        wspace = 64;
        force_wait = 1000;
        q0.push_back(8'h77);
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge clk);
            if (!bus.av_write_n) found = 1;
        end
        check("rst_write_seen", 64'(found), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_strobes", 64'({bus.av_chipselect, bus.av_write_n}), 64'b01);
        q0.delete(); xlog.delete(); grants.delete();
        force_wait = 0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        q0.push_back(8'h78);
        wait_log(3, "rst_count");
        check("rst_kinds", 64'({4'(xlog[0].kind), 4'(xlog[1].kind), 4'(xlog[2].kind)}), 64'h213);
        check("rst_data", 64'(xlog[2].dat), 64'h78);

        // Randomized traffic
        do_reset();
        wspace = 16;
        rand_wait = 1;
        drain_en = 1;
        gen_en = 1;
        rx_mode = 2;
        repeat (4000) @(posedge clk);
        gen_en = 0;
        check("rand_writes_seen", 64'(count_kind(3) > 50), 64'd1);
        check("rand_reads_seen", 64'(count_kind(2) > 10), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
